// File: rtl/cpu6502_pkg.sv
// Shared types and constants for the cpu6502 interrupt sequencer.
package cpu6502_pkg;

    typedef enum logic [1:0] {
        RESET_SEQ = 2'd0,
        IDLE      = 2'd1,
        SERVICE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NMI   = 2'd0,
        RESET = 2'd1,
        IRQ   = 2'd2
    } vector_e;

    localparam logic [7:0] VEC_NMI_LO   = 8'hFA;
    localparam logic [7:0] VEC_RESET_LO = 8'hFC;
    localparam logic [7:0] VEC_IRQ_LO   = 8'hFE;
    localparam logic [7:0] OPCODE_BRK   = 8'h00;

    function automatic logic [7:0] vector_lo(input vector_e v);
        case (v)
            NMI:     vector_lo = VEC_NMI_LO;
            RESET:   vector_lo = VEC_RESET_LO;
            default: vector_lo = VEC_IRQ_LO;
        endcase
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an active-low pin, with a falling-edge pulse
// derived from the synchronised level.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async_n,
    output logic o_level,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] chain_q, chain_d;
    logic                   prev_q, prev_d;

    always_comb begin
        chain_d[0] = i_async_n;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
        prev_d = chain_q[SYNC_STAGES-1];
    end

    // Chain resets high so a pin already low at release still reads as an edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            chain_q <= '1;
            prev_q  <= 1'b1;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign o_level = chain_q[SYNC_STAGES-1];
    assign o_fall  = prev_q & ~chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_control.sv
// Instruction-boundary sequencer: chooses memory opcode or forced BRK for
// reset, NMI and IRQ entry, and supplies the matching vector and B bit.
module interrupt_control
    import cpu6502_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rdy,
    input  logic       i_nmi_n,
    input  logic       i_irq_n,
    input  logic       i_p_i,
    input  logic       i_sync,
    input  logic       i_vector_fetched,
    output logic       o_force_brk,
    output logic [7:0] o_vector_lo,
    output logic       o_b_flag,
    output logic       o_rw_inhibit,
    output logic       o_busy
);

    state_e  state_q, state_d;
    vector_e vec_q, vec_d;
    logic    nmi_latch_q, nmi_latch_d;

    logic nmi_level, nmi_fall;
    logic irq_level, irq_fall_unused;
    logic irq_req;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_async_n (i_nmi_n),
        .o_level   (nmi_level),
        .o_fall    (nmi_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_async_n (i_irq_n),
        .o_level   (irq_level),
        .o_fall    (irq_fall_unused)
    );

    assign irq_req = ~irq_level & ~i_p_i;

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        // Edge capture runs through stalls so no NMI is lost.
        nmi_latch_d = nmi_latch_q | nmi_fall;
        if (i_rdy) begin
            case (state_q)
                RESET_SEQ: begin
                    if (i_vector_fetched) state_d = IDLE;
                end
                IDLE: begin
                    if (i_sync && (nmi_latch_q || irq_req)) begin
                        state_d = SERVICE;
                        vec_d   = nmi_latch_q ? NMI : IRQ;
                    end
                end
                SERVICE: begin
                    if (i_vector_fetched) begin
                        state_d = IDLE;
                        // A fresh edge on the retiring cycle keeps the latch set.
                        if (vec_q == NMI && !nmi_fall) nmi_latch_d = 1'b0;
                    end
                end
                default: state_d = RESET_SEQ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= RESET_SEQ;
            vec_q       <= RESET;
            nmi_latch_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            nmi_latch_q <= nmi_latch_d;
        end
    end

    always_comb begin
        o_force_brk  = 1'b1;
        o_vector_lo  = vector_lo(vec_q);
        o_b_flag     = 1'b0;
        o_rw_inhibit = 1'b0;
        o_busy       = 1'b1;
        case (state_q)
            RESET_SEQ: o_rw_inhibit = 1'b1;
            IDLE: begin
                // Idle outputs serve a fetched software BRK: IRQ vector, B=1.
                o_force_brk = 1'b0;
                o_vector_lo = VEC_IRQ_LO;
                o_b_flag    = 1'b1;
                o_busy      = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_control.sv
// Directed scoreboard bench for interrupt_control: stimulus queues expected
// outputs, a negedge monitor pops and compares them.
module tb_interrupt_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy, nmi_n, irq_n, p_i, sync, vf;
    logic       force_brk, b_flag, rw_inhibit, busy;
    logic [7:0] vector_lo;

    typedef struct {
        string      name;
        logic [11:0] outs;   // {force_brk, vector_lo, b_flag, rw_inhibit, busy}
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    localparam logic [11:0] O_RST = {1'b1, 8'hFC, 1'b0, 1'b1, 1'b1};
    localparam logic [11:0] O_IDL = {1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    localparam logic [11:0] O_SVI = {1'b1, 8'hFE, 1'b0, 1'b0, 1'b1};
    localparam logic [11:0] O_SVN = {1'b1, 8'hFA, 1'b0, 1'b0, 1'b1};

    interrupt_control #(.SYNC_STAGES(2)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_rdy            (rdy),
        .i_nmi_n          (nmi_n),
        .i_irq_n          (irq_n),
        .i_p_i            (p_i),
        .i_sync           (sync),
        .i_vector_fetched (vf),
        .o_force_brk      (force_brk),
        .o_vector_lo      (vector_lo),
        .o_b_flag         (b_flag),
        .o_rw_inhibit     (rw_inhibit),
        .o_busy           (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if ({force_brk, vector_lo, b_flag, rw_inhibit, busy} !== mon_e.outs) begin
                failures++;
                $display("FAIL %s: got brk=%b vec=%h b=%b rwi=%b busy=%b, expected brk=%b vec=%h b=%b rwi=%b busy=%b",
                         mon_e.name, force_brk, vector_lo, b_flag, rw_inhibit, busy,
                         mon_e.outs[11], mon_e.outs[10:3], mon_e.outs[2], mon_e.outs[1], mon_e.outs[0]);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string nm, input logic [11:0] v);
        exp_t e;
        e.name = nm;
        e.outs = v;
        sb_q.push_back(e);
    endtask

    // One-cycle strobe on sync or vf, then check the state it produced.
    task automatic pulse_sync(input string nm, input logic [11:0] v);
        sync = 1'b1; tick(); sync = 1'b0;
        expect_out(nm, v); tick();
    endtask

    task automatic pulse_vf(input string nm, input logic [11:0] v);
        vf = 1'b1; tick(); vf = 1'b0;
        expect_out(nm, v); tick();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; nmi_n = 1'b1; irq_n = 1'b1;
        p_i = 1'b1; sync = 1'b0; vf = 1'b0;
        tick(2);
        expect_out("reset_held", O_RST); tick();
        rst = 1'b0;
        tick(2);
        expect_out("reset_seq_after_release", O_RST); tick();
        pulse_sync("sync_ignored_in_reset_seq", O_RST);
        pulse_vf("reset_seq_to_idle", O_IDL);
        pulse_vf("vf_ignored_in_idle", O_IDL);

        // IRQ taken when unmasked
        irq_n = 1'b0; p_i = 1'b0;
        tick(2);
        pulse_sync("irq_enter_service", O_SVI);
        expect_out("irq_service_hold", O_SVI); tick();
        pulse_vf("irq_service_exit", O_IDL);
        p_i = 1'b1;
        pulse_sync("irq_masked_stays_idle", O_IDL);

        // NMI and IRQ on the same boundary: NMI first, then IRQ
        p_i = 1'b0; nmi_n = 1'b0;
        tick(3);
        nmi_n = 1'b1;
        pulse_sync("nmi_beats_irq", O_SVN);
        pulse_vf("nmi_service_exit", O_IDL);
        pulse_sync("irq_after_nmi", O_SVI);
        pulse_vf("irq_after_nmi_exit", O_IDL);
        irq_n = 1'b1;
        tick(3);

        // NMI pulse during a stall, sync held high throughout
        rdy = 1'b0; sync = 1'b1; nmi_n = 1'b0;
        tick(); nmi_n = 1'b1;
        tick(5);
        expect_out("stall_no_change", O_IDL); tick();
        tick(2);
        expect_out("stall_no_change_late", O_IDL); tick();
        rdy = 1'b1; tick(); sync = 1'b0;
        expect_out("stall_nmi_taken", O_SVN); tick();
        pulse_vf("stall_nmi_exit", O_IDL);
        pulse_sync("nmi_latch_cleared", O_IDL);

        // NMI arriving during IRQ service waits for the next boundary
        irq_n = 1'b0;
        tick(2);
        pulse_sync("irq_service_for_hijack", O_SVI);
        irq_n = 1'b1; nmi_n = 1'b0;
        tick(3);
        nmi_n = 1'b1;
        expect_out("no_hijack_vector", O_SVI); tick();
        pulse_vf("irq_exit_nmi_pending", O_IDL);
        pulse_sync("pending_nmi_taken", O_SVN);
        pulse_vf("pending_nmi_exit", O_IDL);
        pulse_sync("pending_nmi_cleared", O_IDL);

        // Reset mid NMI service discards the pending NMI
        nmi_n = 1'b0;
        tick(3);
        nmi_n = 1'b1;
        pulse_sync("nmi_service_before_reset", O_SVN);
        tick(2);
        rst = 1'b1; #1;
        expect_out("async_reset_mid_service", O_RST);
        tick(2);
        rst = 1'b0;
        tick();
        expect_out("reset_seq_again", O_RST); tick();
        pulse_vf("reset_seq_to_idle_again", O_IDL);
        pulse_sync("nmi_discarded_by_reset", O_IDL);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interrupt_control.md
Name: interrupt_control

Overview:
Sequencer for the cpu6502 core that decides, at each instruction boundary, whether the next opcode comes from memory or is forced to BRK (0x00) to enter the reset, NMI or IRQ sequence.
- Sits beside the Decoder. It consumes the Decoder's boundary and vector-fetch strobes.
- It drives the IR-load override, the vector low-byte, the pushed B bit and the write inhibit used during the reset sequence.
- It owns NMI edge detection, IRQ masking and priority.

Parameters:
SYNC_STAGES, 2, number of flops synchronising i_nmi_n and i_irq_n (minimum 1)

Ports:
i_clk  in  1  core clock
i_reset  in  1  asynchronous, active-high reset
i_rdy  in  1  core ready; low stalls the sequencer
i_nmi_n  in  1  NMI pin, active low, falling-edge triggered
i_irq_n  in  1  IRQ pin, active low, level sensitive
i_p_i  in  1  interrupt-disable flag from P register
i_sync  in  1  Decoder strobe: current cycle is the last of the instruction (next cycle loads IR)
i_vector_fetched  in  1  Decoder strobe: vector high byte is being read this cycle
o_force_brk  out  1  IR load must take 0x00 instead of the data bus
o_vector_lo  out  8  ADL value for vector fetch: 0xFA NMI, 0xFC reset, 0xFE IRQ/BRK
o_b_flag  out  1  value of the B bit pushed with P (1 = software BRK)
o_rw_inhibit  out  1  force read on stack-push cycles (reset sequence only)
o_busy  out  1  an interrupt/reset sequence is in progress

Behaviour:
Reset and clocking:
- Single clock, i_clk, rising edge.
- i_reset is asynchronous and active-high.
- While i_reset is high the block is held in its reset state; it is released on the first i_clk edge after i_reset falls.

State machine:
- States: RESET_SEQ, IDLE, SERVICE.
- Reset values: state = RESET_SEQ, NMI latch = 0, sync chains = 1, vector register = RESET.
- Reset-state outputs: o_force_brk=1, o_vector_lo=0xFC, o_b_flag=0, o_rw_inhibit=1, o_busy=1.

Synchronisers:
- i_nmi_n and i_irq_n each pass through SYNC_STAGES flops.
- NMI edge: the synchronised value goes 1->0. The NMI latch sets one cycle later.
- The NMI latch also sets while i_rdy=0, so edges are never lost during a stall.

IRQ request:
- irq_req = (synchronised irq_n == 0) && !i_p_i.
- It is combinational on the current i_p_i and is not latched; a deasserted IRQ is simply not taken.

Transitions (all gated by i_rdy=1; with i_rdy=0 the state and vector register hold):
- RESET_SEQ -> IDLE on i_vector_fetched.
- IDLE -> SERVICE when i_sync && (nmi_latch || irq_req).
  - Vector register is set to NMI if nmi_latch is set, else IRQ. NMI beats IRQ when both are present on the same boundary.
- SERVICE -> IDLE on i_vector_fetched.
  - If the serviced vector is NMI, the NMI latch clears on this edge.
  - A new NMI edge detected on this same cycle wins and leaves the latch set.

Outputs per state:
- IDLE: o_force_brk=0, o_vector_lo=0xFE, o_b_flag=1, o_rw_inhibit=0, o_busy=0. A fetched BRK opcode therefore uses the IRQ vector with B=1.
- SERVICE: o_force_brk=1, o_vector_lo=0xFA or 0xFE per the vector register, o_b_flag=0, o_rw_inhibit=0, o_busy=1.
- All outputs are decoded from registered state only; there are no combinational input->output paths.

Boundary rules:
- The vector is frozen on entry to SERVICE. An NMI arriving during IRQ service is latched and taken at the next boundary; there is no hijack.
- i_sync is ignored outside IDLE.
- i_vector_fetched is ignored in IDLE.
- Reset asserted mid-sequence returns immediately to RESET_SEQ and discards any pending NMI.
- i_p_i changes take effect at the next boundary evaluation.

Decomposition:
- Shared package cpu6502_pkg:
  - state enum: RESET_SEQ, IDLE, SERVICE
  - vector enum: NMI, RESET, IRQ
  - constants VEC_NMI_LO=8'hFA, VEC_RESET_LO=8'hFC, VEC_IRQ_LO=8'hFE, OPCODE_BRK=8'h00
- One natural sub-module, sync_edge_detect (parameter SYNC_STAGES):
  - outputs: synchronised level and falling-edge pulse
  - instantiated twice, once for NMI and once for IRQ; only the NMI edge pulse is used.

Test Plan:
- Reset release, hold i_rdy=1 -> o_force_brk=1, o_vector_lo=0xFC, o_rw_inhibit=1 until an i_vector_fetched pulse. Next cycle all outputs equal the IDLE values (o_vector_lo=0xFE, o_b_flag=1).
- i_irq_n=0, i_p_i=0, i_sync pulse after 2 sync cycles -> SERVICE with o_vector_lo=0xFE, o_b_flag=0. Repeat with i_p_i=1 -> stays IDLE.
- NMI falling edge and IRQ low before the same i_sync -> o_vector_lo=0xFA. After i_vector_fetched, the next i_sync enters SERVICE with 0xFE.
- NMI 1-cycle low pulse while i_rdy=0 for 10 cycles -> no state change during the stall. First i_sync after i_rdy=1 selects 0xFA.
- NMI edge during IRQ SERVICE -> vector stays 0xFE through i_vector_fetched. The next boundary services 0xFA, and only then does the latch clear.
- i_reset pulsed mid-SERVICE(NMI) -> immediate RESET_SEQ outputs. After reset completes, no NMI is serviced.
